elastic_pipe_reg: RTL

//  Parametrised successor to the fixed EX/MEM-style pipeline registers. One elastic stage
//  for any inter-stage boundary (IF/ID .. MEM/WB): valid/ready handshake, 2-entry skid

---
 rtl/elastic_pipe_reg.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/elastic_pipe_reg.sv
// One elastic pipeline stage: valid/ready handshake with a 2-entry skid buffer,
// synchronous flush of control fields and a saturating stall counter.
module elastic_pipe_reg #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned CTRL_W     = 8,
  parameter bit          CLEAR_DATA = 1'b0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  // State encoding is {s_v, m_v}; 2'b10 is unreachable.
  localparam logic [1:0] StEmpty = 2'b00;
  localparam logic [1:0] StOne   = 2'b01;
  localparam logic [1:0] StFull  = 2'b11;

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic              m_v_q, m_v_d;
  logic              s_v_q, s_v_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
  logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
  logic              rdy_q, rdy_d;
  logic [CNT_W-1:0]  stall_q, stall_d;

  logic [1:0] state;
  logic       accept;
  logic       drain;

  assign state  = {s_v_q, m_v_q};
  assign accept = in_valid & rdy_q;
  assign drain  = m_v_q & out_ready;

  always_comb begin
    m_v_d    = m_v_q;
    s_v_d    = s_v_q;
    m_data_d = m_data_q;
    s_data_d = s_data_q;
    m_ctrl_d = m_ctrl_q;
    s_ctrl_d = s_ctrl_q;

    case (state)
      StEmpty: begin
        if (accept) begin
          m_v_d    = 1'b1;
          m_data_d = in_data;
          m_ctrl_d = in_ctrl;
        end
      end
      StOne: begin
        if (accept && drain) begin
          m_data_d = in_data;
          m_ctrl_d = in_ctrl;
        end else if (accept) begin
          s_v_d    = 1'b1;
          s_data_d = in_data;
          s_ctrl_d = in_ctrl;
        end else if (drain) begin
          m_v_d = 1'b0;
        end
      end
      StFull: begin
        if (drain) begin
          m_data_d = s_data_q;
          m_ctrl_d = s_ctrl_q;
          s_v_d    = 1'b0;
          s_ctrl_d = '0;
        end
      end
      default: begin
        m_v_d = 1'b0;
        s_v_d = 1'b0;
      end
    endcase

    // Flush overrides everything, including a beat accepted in the same cycle.
    if (flush) begin
      m_v_d    = 1'b0;
      s_v_d    = 1'b0;
      m_ctrl_d = '0;
      s_ctrl_d = '0;
      if (CLEAR_DATA) begin
        m_data_d = '0;
        s_data_d = '0;
      end
    end
  end

  // Ready is a flop so it stays low through reset and rises on the first edge after release.
  assign rdy_d = ~s_v_d;

  always_comb begin
    stall_d = stall_q;
    if (m_v_q && !out_ready && (stall_q != CntMax)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_v_q    <= 1'b0;
      s_v_q    <= 1'b0;
      m_data_q <= '0;
      s_data_q <= '0;
      m_ctrl_q <= '0;
      s_ctrl_q <= '0;
      rdy_q    <= 1'b0;
      stall_q  <= '0;
    end else begin
      m_v_q    <= m_v_d;
      s_v_q    <= s_v_d;
      m_data_q <= m_data_d;
      s_data_q <= s_data_d;
      m_ctrl_q <= m_ctrl_d;
      s_ctrl_q <= s_ctrl_d;
      rdy_q    <= rdy_d;
      stall_q  <= stall_d;
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = m_v_q;
  assign out_data  = m_data_q;
  assign out_ctrl  = m_v_q ? m_ctrl_q : '0;
  assign stall_cnt = stall_q;

endmodule
